button_ctrl: RTL and testbench



---
 rtl/button_ctrl.sv | 162 ++++++++++++++++
 tb/tb_button_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/button_ctrl.sv
// button_ctrl: raw pushbutton front end for the LED blink controller.
// The button is synchronised and debounced, then each press is classed as
// short (toggles o_enable on release) or long (steps o_blink_rate once the
// hold threshold is reached).
// Optional build macro BUTTON_CTRL_AUTO_REPEAT_EN: while a long press is
// still held, o_blink_rate keeps stepping every REPEAT_CYCLES cycles.
module button_ctrl #(
   parameter int SYNC_STAGES       = 2,
   parameter int DEBOUNCE_CYCLES   = 16,
   parameter int LONG_PRESS_CYCLES = 1024,
   parameter int REPEAT_CYCLES     = 256
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_btn_raw,
   output logic       o_btn_level,
   output logic       o_short_press,
   output logic       o_long_press,
   output logic       o_enable,
   output logic [3:0] o_blink_rate
);

   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
   localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

   localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_THR = HOLD_W'(LONG_PRESS_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_SAT = '1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HELD = 2'd1,
      S_LONG = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_s;
   logic [DB_W-1:0]        r_db_cnt;
   logic                   r_level;

   state_t                 r_state, w_state_nxt;
   logic [HOLD_W-1:0]      r_hold, w_hold_nxt;
   logic                   r_short, w_short_nxt;
   logic                   r_long, w_long_nxt;
   logic                   r_enable, w_enable_nxt;
   logic [3:0]             r_rate, w_rate_nxt;

`ifdef BUTTON_CTRL_AUTO_REPEAT_EN
   localparam int REP_W = $clog2(REPEAT_CYCLES);
   localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES - 1);
   logic [REP_W-1:0]       r_rep, w_rep_nxt;
`endif

   assign w_s = r_sync[SYNC_STAGES-1];

   // Metastability guard: shift the asynchronous button through the chain
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_sync <= '0;
      else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn_raw};
   end

   // Debounce: level follows s only after DEBOUNCE_CYCLES differing samples in a row
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_db_cnt <= '0;
         r_level  <= 1'b0;
      end else if (w_s == r_level) begin
         r_db_cnt <= '0;
      end else if (r_db_cnt == DB_MAX) begin
         r_level  <= w_s;
         r_db_cnt <= '0;
      end else begin
         r_db_cnt <= r_db_cnt + 1'b1;
      end
   end

   // Press FSM state and registered outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= S_IDLE;
         r_hold   <= '0;
         r_short  <= 1'b0;
         r_long   <= 1'b0;
         r_enable <= 1'b0;
         r_rate   <= 4'd0;
      end else begin
         r_state  <= w_state_nxt;
         r_hold   <= w_hold_nxt;
         r_short  <= w_short_nxt;
         r_long   <= w_long_nxt;
         r_enable <= w_enable_nxt;
         r_rate   <= w_rate_nxt;
      end
   end

`ifdef BUTTON_CTRL_AUTO_REPEAT_EN
   // Auto-repeat counter, only meaningful while in S_LONG
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_rep <= '0;
      else          r_rep <= w_rep_nxt;
   end
`endif

   // Press classification; release always wins over the long threshold
   always_comb begin
      w_state_nxt  = r_state;
      w_hold_nxt   = r_hold;
      w_short_nxt  = 1'b0;
      w_long_nxt   = 1'b0;
      w_enable_nxt = r_enable;
      w_rate_nxt   = r_rate;
`ifdef BUTTON_CTRL_AUTO_REPEAT_EN
      w_rep_nxt    = r_rep;
`endif
      case (r_state)
         S_IDLE: begin
            if (r_level) begin
               w_state_nxt = S_HELD;
               w_hold_nxt  = HOLD_W'(1);
            end
         end
         S_HELD: begin
            if (!r_level) begin
               w_state_nxt  = S_IDLE;
               w_short_nxt  = 1'b1;
               w_enable_nxt = ~r_enable;
            end else if (r_hold == HOLD_THR) begin
               w_state_nxt = S_LONG;
               w_long_nxt  = 1'b1;
               w_rate_nxt  = r_rate + 4'd1;
`ifdef BUTTON_CTRL_AUTO_REPEAT_EN
               w_rep_nxt   = '0;
`endif
            end else if (r_hold != HOLD_SAT) begin
               w_hold_nxt = r_hold + 1'b1;
            end
         end
         S_LONG: begin
            if (!r_level) begin
               w_state_nxt = S_IDLE;
            end
`ifdef BUTTON_CTRL_AUTO_REPEAT_EN
            else if (r_rep == REP_MAX) begin
               w_long_nxt = 1'b1;
               w_rate_nxt = r_rate + 4'd1;
               w_rep_nxt  = '0;
            end else begin
               w_rep_nxt = r_rep + 1'b1;
            end
`endif
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign o_btn_level   = r_level;
   assign o_short_press = r_short;
   assign o_long_press  = r_long;
   assign o_enable      = r_enable;
   assign o_blink_rate  = r_rate;

endmodule

// File: tb/tb_button_ctrl.sv
// tb_button_ctrl: table of press lengths with expected enable/rate, plus
// hand sequences for reset, bounce, rate wrap and mid-press reset. Every
// expected pulse is queued with its cycle when the press is driven and
// popped by the monitor when the DUT pulses.
module tb_button_ctrl;

   localparam int SYNC = 2;
   localparam int DB   = 4;
   localparam int LONG = 20;
   localparam int REP  = 8;
   localparam int LAT  = SYNC + DB;   // raw step to debounced level change

   logic       clk = 1'b0;
   logic       rst_n;
   logic       raw;
   logic       o_btn_level, o_short_press, o_long_press, o_enable;
   logic [3:0] o_blink_rate;

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;
   logic lvl_seen = 1'b0;

   typedef struct { int kind; int cyc; } ev_t;
   ev_t exp_q[$];

   typedef struct {
      int         hi;
      int         kind;     // 0 none, 1 short, 2 long
      logic       exp_en;
      logic [3:0] rate_nr;  // expected rate without auto-repeat
      logic [3:0] rate_ar;  // expected rate with auto-repeat
   } vec_t;
   vec_t vecs[6];

   button_ctrl #(
      .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB),
      .LONG_PRESS_CYCLES(LONG), .REPEAT_CYCLES(REP)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_btn_raw(raw),
      .o_btn_level(o_btn_level), .o_short_press(o_short_press),
      .o_long_press(o_long_press), .o_enable(o_enable),
      .o_blink_rate(o_blink_rate)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(string name, int act, int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Monitor: every pulse must match the head of the expectation queue
   always @(negedge clk) begin
      if (o_btn_level) lvl_seen = 1'b1;
      if (rst_n && (o_short_press || o_long_press)) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_pulse: got short=%0b long=%0b expected none (cycle %0d)",
                     o_short_press, o_long_press, cyc);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            check("pulse_kind", (o_short_press && o_long_press) ? 3 : (o_long_press ? 2 : 1), e.kind);
            check("pulse_cycle", cyc, e.cyc);
         end
      end
   end

   // Queue the pulses a press of h raw-high cycles starting at cycle s must make
   function automatic void push_press(int s, int h, int kind);
      ev_t e;
      if (kind == 1) begin
         e.kind = 1; e.cyc = s + h + LAT + 1;
         exp_q.push_back(e);
      end else if (kind == 2) begin
         e.kind = 2; e.cyc = s + LAT + LONG + 1;
         exp_q.push_back(e);
`ifdef BUTTON_CTRL_AUTO_REPEAT_EN
         for (int t = s + LAT + LONG + 1 + REP; t <= s + h + LAT; t += REP) begin
            e.cyc = t;
            exp_q.push_back(e);
         end
`endif
      end
   endfunction

   task automatic press(input int h, input int kind, input int idle);
      int s;
      s = cyc;
      push_press(s, h, kind);
      raw = 1'b1;
      repeat (h) @(negedge clk);
      raw = 1'b0;
      repeat (idle) @(negedge clk);
      check("pulses_outstanding", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      int r;
      int bl[6];
      logic [3:0] rate0;
      ev_t e;

      vecs[0] = '{hi: 12, kind: 1, exp_en: 1'b0, rate_nr: 4'd0, rate_ar: 4'd0};
      vecs[1] = '{hi: 12, kind: 1, exp_en: 1'b1, rate_nr: 4'd0, rate_ar: 4'd0};
      vecs[2] = '{hi: 40, kind: 2, exp_en: 1'b1, rate_nr: 4'd1, rate_ar: 4'd3};
      vecs[3] = '{hi: 20, kind: 1, exp_en: 1'b0, rate_nr: 4'd1, rate_ar: 4'd3};
      vecs[4] = '{hi: 21, kind: 2, exp_en: 1'b0, rate_nr: 4'd2, rate_ar: 4'd4};
      vecs[5] = '{hi: 3,  kind: 0, exp_en: 1'b0, rate_nr: 4'd2, rate_ar: 4'd4};
      bl = '{3, 1, 2, 3, 3, 1};

      // Reset with the button held, then it counts as a fresh press
      rst_n = 1'b0;
      raw   = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outputs",
            int'({o_btn_level, o_short_press, o_long_press, o_enable, o_blink_rate}), 0);
      rst_n = 1'b1;
      r = cyc;
      e.kind = 1; e.cyc = r + 8 + LAT + 1;
      exp_q.push_back(e);
      repeat (LAT - 1) @(negedge clk);
      check("level_before_rise", int'(o_btn_level), 0);
      @(negedge clk);
      check("level_rise_after_reset", int'(o_btn_level), 1);
      repeat (2) @(negedge clk);
      raw = 1'b0;
      repeat (25) @(negedge clk);
      check("pulses_outstanding", exp_q.size(), 0);
      exp_q.delete();
      check("enable_after_first", int'(o_enable), 1);

      // Bounce: glitches shorter than DB samples never reach the level
      lvl_seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         raw = (i % 2 == 0);
         repeat (bl[i]) @(negedge clk);
      end
      raw = 1'b0;
      repeat (15) @(negedge clk);
      check("bounce_level", int'(lvl_seen), 0);
      check("bounce_enable", int'(o_enable), 1);

      // Table of presses
      for (int i = 0; i < 6; i++) begin
         press(vecs[i].hi, vecs[i].kind, 30);
         check("vec_enable", int'(o_enable), int'(vecs[i].exp_en));
`ifdef BUTTON_CTRL_AUTO_REPEAT_EN
         check("vec_rate", int'(o_blink_rate), int'(vecs[i].rate_ar));
`else
         check("vec_rate", int'(o_blink_rate), int'(vecs[i].rate_nr));
`endif
      end

      // Sixteen long presses bring the rate back where it started
      rate0 = o_blink_rate;
      for (int i = 0; i < 16; i++) press(22, 2, 30);
      check("rate_wrap", int'(o_blink_rate), int'(rate0));
      check("wrap_enable", int'(o_enable), 0);

      // Reset while held: immediate clear, short remainder never debounces
      raw = 1'b1;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset_outputs",
            int'({o_btn_level, o_short_press, o_long_press, o_enable, o_blink_rate}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      lvl_seen = 1'b0;
      repeat (3) @(negedge clk);
      raw = 1'b0;
      repeat (30) @(negedge clk);
      check("midreset_level", int'(lvl_seen), 0);
      check("midreset_rate", int'(o_blink_rate), 0);
      check("midreset_enable", int'(o_enable), 0);

      // Long hold of 60 cycles: one pulse, or pulse plus repeats
      press(60, 2, 30);
`ifdef BUTTON_CTRL_AUTO_REPEAT_EN
      check("hold60_rate", int'(o_blink_rate), 5);
`else
      check("hold60_rate", int'(o_blink_rate), 1);
`endif
      check("hold60_enable", int'(o_enable), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
